// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions.
// State encoding, byte-select constant and byte-offset helper.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } dma_state_t;

    // Widest supported select field; narrower buses take the low bits.
    localparam logic [7:0] SEL_ALL = 8'hFF;

    // Number of byte-offset address bits for a given select width.
    function automatic int off_bits(input int sw);
        return (sw <= 1) ? 0 : $clog2(sw);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus-response watchdog for Wishbone initiators.
// Counts idle wait cycles and flags expiry on the TO-th one.
module wb_watchdog #(
    parameter int TO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TO < 2) ? 1 : $clog2(TO);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(TO - 1));

    // Wait-cycle counter; held at zero while cleared, saturates at expiry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_dma_copy.sv
// Wishbone memory-to-memory copy initiator.
// One read then one write per word, with error and timeout abort.
module wb_dma_copy
    import wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW >> 3,
    parameter int LW = 16,
    parameter int TO = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_dst,
    input  logic [LW-1:0] i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [AW-1:0] o_wb_adr,
    output logic [SW-1:0] o_wb_sel,
    output logic          o_wb_we,
    output logic [DW-1:0] o_wb_dat,
    input  logic [DW-1:0] i_wb_dat,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    input  logic          i_wb_ack,
    input  logic          i_wb_err
);

    localparam int OB = off_bits(SW);
    localparam logic [AW-1:0] AMASK = ~AW'((1 << OB) - 1);
    localparam logic [AW-1:0] STEP  = AW'(SW);
    localparam logic [SW-1:0] SEL   = SEL_ALL[SW-1:0];

    dma_state_t    state;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] cnt;
    logic [AW-1:0] src_nxt;
    logic [AW-1:0] dst_nxt;
    logic [AW-1:0] start_src;
    logic [AW-1:0] start_dst;
    logic          phase;
    logic          wd_en;
    logic          wd_clr;
    logic          wd_expire;
    logic          abort;

    // Next addresses, aligned start addresses and abort/watchdog control.
    always_comb begin
        src_nxt   = src + STEP;
        dst_nxt   = dst + STEP;
        start_src = i_src & AMASK;
        start_dst = i_dst & AMASK;
        phase     = (state == RD) || (state == WR);
        wd_en     = phase && !i_wb_ack && !i_wb_err;
        wd_clr    = !wd_en;
        abort     = phase && (i_wb_err || wd_expire);
    end

    wb_watchdog #(
        .TO(TO)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Strobe mirrors cycle: single transfers only.
    assign o_wb_stb = o_wb_cyc;

    // Command sequencer; every output is loaded on the edge that changes phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src      <= '0;
            dst      <= '0;
            cnt      <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_wb_adr <= '0;
            o_wb_sel <= SEL;
            o_wb_we  <= 1'b0;
            o_wb_dat <= '0;
            o_wb_cyc <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            o_wb_sel <= SEL;
            if (abort) begin
                o_err    <= 1'b1;
                o_done   <= 1'b1;
                o_wb_cyc <= 1'b0;
                o_wb_we  <= 1'b0;
                state    <= DONE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_start) begin
                            src    <= start_src;
                            dst    <= start_dst;
                            cnt    <= i_len;
                            o_err  <= 1'b0;
                            o_busy <= 1'b1;
                            if (i_len == '0) begin
                                o_done <= 1'b1;
                                state  <= DONE;
                            end else begin
                                o_wb_cyc <= 1'b1;
                                o_wb_we  <= 1'b0;
                                o_wb_adr <= start_src;
                                state    <= RD;
                            end
                        end
                    end
                    RD: begin
                        if (i_wb_ack) begin
                            o_wb_dat <= i_wb_dat;
                            o_wb_we  <= 1'b1;
                            o_wb_adr <= dst;
                            state    <= WR;
                        end
                    end
                    WR: begin
                        if (i_wb_ack) begin
                            src <= src_nxt;
                            dst <= dst_nxt;
                            cnt <= cnt - 1'b1;
                            if (cnt == LW'(1)) begin
                                o_wb_cyc <= 1'b0;
                                o_wb_we  <= 1'b0;
                                o_done   <= 1'b1;
                                state    <= DONE;
                            end else begin
                                o_wb_we  <= 1'b0;
                                o_wb_adr <= src_nxt;
                                state    <= RD;
                            end
                        end
                    end
                    DONE: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
